// File: rtl/nn_sram_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | nn_sram_arbiter_pkg : shared state encodings and address constants
// | Revision 1.0
// +----------------------------------------------------------------------------
package nn_sram_arbiter_pkg;

   localparam int c_SRAM_ADDR_W = 17;

   localparam logic [c_SRAM_ADDR_W-1:0] c_FWD_WEIGHT_BASE = 17'h00000;
   localparam logic [c_SRAM_ADDR_W-1:0] c_BWD_WEIGHT_BASE = 17'h10000;

   localparam logic c_OWNER_A = 1'b0;
   localparam logic c_OWNER_B = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_ADDR   = 3'd1,
      ST_RD_WAIT   = 3'd2,
      ST_RD_CAP    = 3'd3,
      ST_WR_SETUP  = 3'd4,
      ST_WR_STROBE = 3'd5,
      ST_WR_HOLD   = 3'd6
   } state_t;

endpackage
`default_nettype wire

// File: rtl/nn_sram_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | nn_sram_arbiter_if : engine request ports and dual byte-SRAM pin bundle
// | Revision 1.0
// +----------------------------------------------------------------------------
interface nn_sram_arbiter_if
   import nn_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W = c_SRAM_ADDR_W
) ();

   logic              a_req;
   logic              a_we;
   logic [ADDR_W-1:0] a_addr;
   logic [15:0]       a_wdata;
   logic              a_ack;
   logic [15:0]       a_rdata;

   logic              b_req;
   logic              b_we;
   logic [ADDR_W-1:0] b_addr;
   logic [15:0]       b_wdata;
   logic              b_ack;
   logic [15:0]       b_rdata;

   logic [ADDR_W-1:0] sram0_addr;
   logic [7:0]        sram0_data_output;
   logic [7:0]        sram0_data_input;
   logic              sram0_output_en;
   logic              sram0_cs_n;
   logic              sram0_oe_n;
   logic              sram0_we_n;

   logic [ADDR_W-1:0] sram1_addr;
   logic [7:0]        sram1_data_output;
   logic [7:0]        sram1_data_input;
   logic              sram1_output_en;
   logic              sram1_cs_n;
   logic              sram1_oe_n;
   logic              sram1_we_n;

   logic              busy;
   logic              owner;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_ack, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_ack, b_rdata,
      output sram0_addr, sram0_data_output, sram0_output_en,
      output sram0_cs_n, sram0_oe_n, sram0_we_n,
      input  sram0_data_input,
      output sram1_addr, sram1_data_output, sram1_output_en,
      output sram1_cs_n, sram1_oe_n, sram1_we_n,
      input  sram1_data_input,
      output busy, owner
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_ack, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_ack, b_rdata,
      input  sram0_addr, sram0_data_output, sram0_output_en,
      input  sram0_cs_n, sram0_oe_n, sram0_we_n,
      output sram0_data_input,
      input  sram1_addr, sram1_data_output, sram1_output_en,
      input  sram1_cs_n, sram1_oe_n, sram1_we_n,
      output sram1_data_input,
      input  busy, owner
   );

endinterface
`default_nettype wire

// File: rtl/nn_sram_arbiter_rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | rr_arb2 : two-way round-robin grant with owner register
// | Revision 1.0
// +----------------------------------------------------------------------------
module rr_arb2
   import nn_sram_arbiter_pkg::*;
(
   input  wire  clk,
   input  wire  rst,
   input  wire  req_a_i,
   input  wire  req_b_i,
   input  wire  en_i,
   output logic gnt_valid_o,
   output logic gnt_b_o,
   output logic owner_o
);

   logic owner_q;
   logic owner_d;

   // On a tie the port that did not win last time is served.
   assign gnt_valid_o = req_a_i | req_b_i;
   assign gnt_b_o     = req_b_i & (~req_a_i | (owner_q == c_OWNER_A));
   assign owner_o     = owner_q;

   always_comb begin
      owner_d = owner_q;
      if (en_i && gnt_valid_o) begin
         owner_d = gnt_b_o;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= c_OWNER_B;
      end else begin
         owner_q <= owner_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/nn_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | nn_sram_arbiter : shares two byte-wide weight SRAMs between two engines
// | Revision 1.0
// +----------------------------------------------------------------------------
module nn_sram_arbiter
   import nn_sram_arbiter_pkg::*;
#(
   parameter int ADDR_W  = c_SRAM_ADDR_W,
   parameter int RD_WAIT = 1
) (
   input  wire              clk,
   input  wire              rst,
   nn_sram_arbiter_if.slave bus
);

   localparam logic [1:0] c_WAIT_LOAD = 2'(RD_WAIT - 1);

   state_t            state_q, state_d;
   logic [1:0]        wait_q, wait_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [15:0]       wdata_q, wdata_d;
   logic              cs_n_q, cs_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              drive_q, drive_d;
   logic              a_ack_q, a_ack_d;
   logic              b_ack_q, b_ack_d;
   logic [15:0]       a_rdata_q, a_rdata_d;
   logic [15:0]       b_rdata_q, b_rdata_d;

   logic              w_idle;
   logic              w_gnt_valid;
   logic              w_gnt_b;
   logic              w_owner;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [15:0]       w_sel_wdata;
   logic [15:0]       w_rd_word;

   assign w_idle      = (state_q == ST_IDLE);
   assign w_sel_we    = w_gnt_b ? bus.b_we    : bus.a_we;
   assign w_sel_addr  = w_gnt_b ? bus.b_addr  : bus.a_addr;
   assign w_sel_wdata = w_gnt_b ? bus.b_wdata : bus.a_wdata;
   assign w_rd_word   = {bus.sram0_data_input, bus.sram1_data_input};

   rr_arb2 u_arb (
      .clk         (clk),
      .rst         (rst),
      .req_a_i     (bus.a_req),
      .req_b_i     (bus.b_req),
      .en_i        (w_idle),
      .gnt_valid_o (w_gnt_valid),
      .gnt_b_o     (w_gnt_b),
      .owner_o     (w_owner)
   );

   // Strobes are computed one cycle ahead so every SRAM pin leaves a flop.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cs_n_d    = 1'b1;
      oe_n_d    = 1'b1;
      we_n_d    = 1'b1;
      drive_d   = 1'b0;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (w_gnt_valid) begin
               addr_d = w_sel_addr;
               if (w_sel_we) begin
                  wdata_d = w_sel_wdata;
                  drive_d = 1'b1;
                  state_d = ST_WR_SETUP;
               end else begin
                  cs_n_d  = 1'b0;
                  oe_n_d  = 1'b0;
                  state_d = ST_RD_ADDR;
               end
            end
         end
         ST_RD_ADDR: begin
            cs_n_d  = 1'b0;
            oe_n_d  = 1'b0;
            wait_d  = c_WAIT_LOAD;
            state_d = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            if (wait_q == 2'd0) begin
               if (w_owner == c_OWNER_B) begin
                  b_rdata_d = w_rd_word;
                  b_ack_d   = 1'b1;
               end else begin
                  a_rdata_d = w_rd_word;
                  a_ack_d   = 1'b1;
               end
               state_d = ST_RD_CAP;
            end else begin
               cs_n_d = 1'b0;
               oe_n_d = 1'b0;
               wait_d = wait_q - 2'd1;
            end
         end
         ST_RD_CAP: begin
            state_d = ST_IDLE;
         end
         ST_WR_SETUP: begin
            cs_n_d  = 1'b0;
            we_n_d  = 1'b0;
            drive_d = 1'b1;
            state_d = ST_WR_STROBE;
         end
         ST_WR_STROBE: begin
            drive_d = 1'b1;
            a_ack_d = (w_owner == c_OWNER_A);
            b_ack_d = (w_owner == c_OWNER_B);
            state_d = ST_WR_HOLD;
         end
         ST_WR_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         wait_q    <= 2'd0;
         addr_q    <= '0;
         wdata_q   <= 16'h0000;
         cs_n_q    <= 1'b1;
         oe_n_q    <= 1'b1;
         we_n_q    <= 1'b1;
         drive_q   <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_rdata_q <= 16'h0000;
         b_rdata_q <= 16'h0000;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cs_n_q    <= cs_n_d;
         oe_n_q    <= oe_n_d;
         we_n_q    <= we_n_d;
         drive_q   <= drive_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
      end
   end

   assign bus.a_ack             = a_ack_q;
   assign bus.a_rdata           = a_rdata_q;
   assign bus.b_ack             = b_ack_q;
   assign bus.b_rdata           = b_rdata_q;

   assign bus.sram0_addr        = addr_q;
   assign bus.sram0_data_output = wdata_q[15:8];
   assign bus.sram0_output_en   = drive_q;
   assign bus.sram0_cs_n        = cs_n_q;
   assign bus.sram0_oe_n        = oe_n_q;
   assign bus.sram0_we_n        = we_n_q;

   assign bus.sram1_addr        = addr_q;
   assign bus.sram1_data_output = wdata_q[7:0];
   assign bus.sram1_output_en   = drive_q;
   assign bus.sram1_cs_n        = cs_n_q;
   assign bus.sram1_oe_n        = oe_n_q;
   assign bus.sram1_we_n        = we_n_q;

   assign bus.busy              = ~w_idle;
   assign bus.owner             = w_owner;

endmodule
`default_nettype wire

// File: tb/tb_nn_sram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | tb_nn_sram_arbiter : directed and randomized checks against SRAM models
// | Revision 1.0
// +----------------------------------------------------------------------------
module tb_nn_sram_arbiter;
   import nn_sram_arbiter_pkg::*;

   localparam int c_AW    = c_SRAM_ADDR_W;
   localparam int c_DEPTH = 1 << c_AW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   last_b = 1'b1;

   logic [15:0] ref_mem [logic [c_AW-1:0]];

   always #5 clk = ~clk;

   nn_sram_arbiter_if #(.ADDR_W(c_AW)) bus1 ();
   nn_sram_arbiter_if #(.ADDR_W(c_AW)) bus3 ();

   nn_sram_arbiter #(.ADDR_W(c_AW), .RD_WAIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
   nn_sram_arbiter #(.ADDR_W(c_AW), .RD_WAIT(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   // Byte-wide SRAM models: asynchronous read, write on a cycle with cs_n and we_n low.
   logic [7:0]      m1_hi [c_DEPTH];
   logic [7:0]      m1_lo [c_DEPTH];
   logic [7:0]      m3_hi [c_DEPTH];
   logic [7:0]      m3_lo [c_DEPTH];
   logic            pre_we   = 1'b0;
   logic [c_AW-1:0] pre_addr = '0;
   logic [15:0]     pre_data = 16'h0000;

   always @(posedge clk) begin
      if (pre_we) begin
         m1_hi[pre_addr] <= pre_data[15:8];
         m1_lo[pre_addr] <= pre_data[7:0];
         m3_hi[pre_addr] <= pre_data[15:8];
         m3_lo[pre_addr] <= pre_data[7:0];
      end
      if (!bus1.sram0_cs_n && !bus1.sram0_we_n) m1_hi[bus1.sram0_addr] <= bus1.sram0_data_output;
      if (!bus1.sram1_cs_n && !bus1.sram1_we_n) m1_lo[bus1.sram1_addr] <= bus1.sram1_data_output;
      if (!bus3.sram0_cs_n && !bus3.sram0_we_n) m3_hi[bus3.sram0_addr] <= bus3.sram0_data_output;
      if (!bus3.sram1_cs_n && !bus3.sram1_we_n) m3_lo[bus3.sram1_addr] <= bus3.sram1_data_output;
   end

   assign bus1.sram0_data_input = (!bus1.sram0_cs_n && !bus1.sram0_oe_n) ? m1_hi[bus1.sram0_addr] : 8'h5A;
   assign bus1.sram1_data_input = (!bus1.sram1_cs_n && !bus1.sram1_oe_n) ? m1_lo[bus1.sram1_addr] : 8'h5A;
   assign bus3.sram0_data_input = (!bus3.sram0_cs_n && !bus3.sram0_oe_n) ? m3_hi[bus3.sram0_addr] : 8'h5A;
   assign bus3.sram1_data_input = (!bus3.sram1_cs_n && !bus3.sram1_oe_n) ? m3_lo[bus3.sram1_addr] : 8'h5A;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [c_AW-1:0] a, input logic [15:0] d);
      pre_addr = a;
      pre_data = d;
      pre_we   = 1'b1;
      tick();
      pre_we   = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("inv1_we_oe",    32'(!bus1.sram0_we_n && !bus1.sram0_oe_n), 32'd0);
         chk("inv1_acks",     32'(bus1.a_ack && bus1.b_ack), 32'd0);
         chk("inv1_drive_oe", 32'(bus1.sram0_output_en && !bus1.sram0_oe_n), 32'd0);
         chk("inv3_we_oe",    32'(!bus3.sram0_we_n && !bus3.sram0_oe_n), 32'd0);
      end
   end

   // One round: each chosen port issues one access; order and timing follow the arbitration rule.
   task automatic run_round(input bit ra, input bit rb, input bit wa, input bit wb,
                            input logic [c_AW-1:0] aa, input logic [c_AW-1:0] ab,
                            input logic [15:0] da, input logic [15:0] db);
      bit first_b;
      int ta;
      int tb;
      first_b = (ra && rb) ? !last_b : rb;
      ta = 0;
      tb = 0;
      if (ra) ta = (rb && first_b) ? 7 : 3;
      if (rb) tb = (ra && !first_b) ? 7 : 3;
      bus1.a_req = ra; bus1.a_we = wa; bus1.a_addr = aa; bus1.a_wdata = da;
      bus1.b_req = rb; bus1.b_we = wb; bus1.b_addr = ab; bus1.b_wdata = db;
      for (int t = 1; t <= 8; t++) begin
         tick();
         chk("rnd_a_ack", 32'(bus1.a_ack), 32'(t == ta));
         chk("rnd_b_ack", 32'(bus1.b_ack), 32'(t == tb));
         if (t == ta) begin
            if (wa) ref_mem[aa] = da;
            else    chk("rnd_a_rdata", 32'(bus1.a_rdata), 32'(ref_mem[aa]));
            bus1.a_req = 1'b0;
         end
         if (t == tb) begin
            if (wb) ref_mem[ab] = db;
            else    chk("rnd_b_rdata", 32'(bus1.b_rdata), 32'(ref_mem[ab]));
            bus1.b_req = 1'b0;
         end
      end
      last_b = (ra && rb) ? !first_b : rb;
      chk("rnd_owner", 32'(bus1.owner), 32'(last_b));
   endtask

   initial begin
      logic [15:0]     d_b;
      logic [15:0]     d_3;
      logic [15:0]     d_p;
      logic [c_AW-1:0] pool [8];

      bus1.a_req = 0; bus1.a_we = 0; bus1.a_addr = '0; bus1.a_wdata = '0;
      bus1.b_req = 0; bus1.b_we = 0; bus1.b_addr = '0; bus1.b_wdata = '0;
      bus3.a_req = 0; bus3.a_we = 0; bus3.a_addr = '0; bus3.a_wdata = '0;
      bus3.b_req = 0; bus3.b_we = 0; bus3.b_addr = '0; bus3.b_wdata = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      chk("rst_busy",   32'(bus1.busy), 32'd0);
      chk("rst_owner",  32'(bus1.owner), 32'd1);
      chk("rst_cs_n",   32'({bus1.sram0_cs_n, bus1.sram1_cs_n}), 32'd3);
      chk("rst_oe_n",   32'({bus1.sram0_oe_n, bus1.sram1_oe_n}), 32'd3);
      chk("rst_we_n",   32'({bus1.sram0_we_n, bus1.sram1_we_n}), 32'd3);
      chk("rst_drive",  32'({bus1.sram0_output_en, bus1.sram1_output_en}), 32'd0);
      chk("rst_acks",   32'({bus1.a_ack, bus1.b_ack}), 32'd0);
      chk("rst_rdata",  32'({bus1.a_rdata, bus1.b_rdata}), 32'd0);
      chk("rst_addr",   32'(bus1.sram0_addr), 32'd0);
      chk("rst_wdata",  32'({bus1.sram0_data_output, bus1.sram1_data_output}), 32'd0);

      // A writes 0xBEEF to 0x00010
      bus1.a_req = 1; bus1.a_we = 1; bus1.a_addr = 17'h00010; bus1.a_wdata = 16'hBEEF;
      tick();
      chk("wr_setup_drive", 32'(bus1.sram0_output_en), 32'd1);
      chk("wr_setup_we_n",  32'(bus1.sram0_we_n), 32'd1);
      chk("wr_setup_cs_n",  32'(bus1.sram1_cs_n), 32'd1);
      chk("wr_setup_bytes", 32'({bus1.sram0_data_output, bus1.sram1_data_output}), 32'hBEEF);
      chk("wr_setup_addr",  32'(bus1.sram1_addr), 32'h00010);
      chk("wr_owner",       32'(bus1.owner), 32'd0);
      tick();
      chk("wr_strobe_we_n", 32'({bus1.sram0_we_n, bus1.sram1_we_n}), 32'd0);
      chk("wr_strobe_cs_n", 32'({bus1.sram0_cs_n, bus1.sram1_cs_n}), 32'd0);
      chk("wr_strobe_ack",  32'(bus1.a_ack), 32'd0);
      tick();
      chk("wr_hold_ack",    32'(bus1.a_ack), 32'd1);
      chk("wr_hold_we_n",   32'(bus1.sram0_we_n), 32'd1);
      chk("wr_hold_drive",  32'(bus1.sram1_output_en), 32'd1);
      bus1.a_req = 0;
      tick();
      chk("wr_idle_drive",  32'(bus1.sram0_output_en), 32'd0);
      chk("wr_idle_ack",    32'(bus1.a_ack), 32'd0);
      chk("wr_mem",         32'({m1_hi[17'h00010], m1_lo[17'h00010]}), 32'hBEEF);

      // A reads it back
      bus1.a_req = 1; bus1.a_we = 0; bus1.a_addr = 17'h00010;
      tick();
      chk("rd_addr_cs_oe",  32'({bus1.sram0_cs_n, bus1.sram0_oe_n}), 32'd0);
      chk("rd_addr_drive",  32'(bus1.sram0_output_en), 32'd0);
      tick();
      chk("rd_wait_ack",    32'(bus1.a_ack), 32'd0);
      tick();
      chk("rd_cap_ack",     32'(bus1.a_ack), 32'd1);
      chk("rd_cap_data",    32'(bus1.a_rdata), 32'hBEEF);
      chk("rd_cap_oe_n",    32'(bus1.sram0_oe_n), 32'd1);
      bus1.a_req = 0;
      tick();

      // Contention from the first IDLE after reset: A, B, A, B
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      bus1.a_req = 1; bus1.a_we = 0; bus1.a_addr = 17'h00010;
      bus1.b_req = 1; bus1.b_we = 0; bus1.b_addr = 17'h00010;
      for (int t = 1; t <= 15; t++) begin
         tick();
         chk("alt_a_ack", 32'(bus1.a_ack), 32'(t == 3 || t == 11));
         chk("alt_b_ack", 32'(bus1.b_ack), 32'(t == 7 || t == 15));
         if (t == 3)  chk("alt_a_rdata", 32'(bus1.a_rdata), 32'hBEEF);
         if (t == 7)  chk("alt_b_rdata", 32'(bus1.b_rdata), 32'hBEEF);
         if (t == 15) begin
            bus1.a_req = 0;
            bus1.b_req = 0;
         end
      end
      tick();
      chk("alt_idle", 32'(bus1.busy), 32'd0);

      // B write then immediate B read of the same word
      d_b = 16'($urandom);
      bus1.b_req = 1; bus1.b_we = 1; bus1.b_addr = 17'h00123; bus1.b_wdata = d_b;
      for (int t = 1; t <= 7; t++) begin
         tick();
         chk("bwr_b_ack", 32'(bus1.b_ack), 32'(t == 3 || t == 7));
         if (t == 3) bus1.b_we = 0;
         if (t == 4) begin
            chk("turn_drive", 32'(bus1.sram0_output_en), 32'd0);
            chk("turn_busy",  32'(bus1.busy), 32'd0);
         end
         if (t == 7) begin
            chk("bwr_rdata", 32'(bus1.b_rdata), 32'(d_b));
            bus1.b_req = 0;
         end
      end
      tick();

      // Reset in the middle of the write strobe
      bus1.a_req = 1; bus1.a_we = 1; bus1.a_addr = 17'h00020; bus1.a_wdata = 16'h1234;
      tick();
      tick();
      chk("rstw_pre_we_n", 32'(bus1.sram0_we_n), 32'd0);
      #2;
      rst = 1'b1;
      #1;
      chk("rstw_cs_n",  32'({bus1.sram0_cs_n, bus1.sram1_cs_n}), 32'd3);
      chk("rstw_we_n",  32'({bus1.sram0_we_n, bus1.sram1_we_n}), 32'd3);
      chk("rstw_drive", 32'(bus1.sram0_output_en), 32'd0);
      chk("rstw_busy",  32'(bus1.busy), 32'd0);
      bus1.a_req = 0;
      tick();
      chk("rstw_ack", 32'(bus1.a_ack), 32'd0);
      rst = 1'b0;
      tick();
      chk("rstw_idle", 32'(bus1.busy), 32'd0);
      chk("rstw_ack2", 32'(bus1.a_ack), 32'd0);

      // RD_WAIT = 3 at the top address
      d_3 = 16'($urandom);
      preload(17'h1FFFF, d_3);
      bus3.a_req = 1; bus3.a_we = 0; bus3.a_addr = 17'h1FFFF;
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("rw3_addr", 32'(bus3.sram0_addr), 32'h1FFFF);
         chk("rw3_ack",  32'(bus3.a_ack), 32'(t == 5));
         chk("rw3_cs_n", 32'(bus3.sram1_cs_n), 32'(t >= 5));
         if (t == 5) begin
            chk("rw3_rdata", 32'(bus3.a_rdata), 32'(d_3));
            bus3.a_req = 0;
         end
      end

      // Randomized rounds against the reference memory and arbitration rule
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      last_b = 1'b1;
      for (int i = 0; i < 8; i++) begin
         pool[i] = c_AW'($urandom_range(0, c_DEPTH - 1));
         d_p     = 16'($urandom);
         preload(pool[i], d_p);
         ref_mem[pool[i]] = d_p;
      end
      for (int r = 0; r < 24; r++) begin
         bit ra;
         bit rb;
         ra = 1'($urandom);
         rb = 1'($urandom);
         if (!ra && !rb) ra = 1'b1;
         run_round(ra, rb, 1'($urandom), 1'($urandom),
                   pool[$urandom_range(0, 7)], pool[$urandom_range(0, 7)],
                   16'($urandom), 16'($urandom));
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
